// File: rtl/param_stack_pkg.sv
// Shared types and the per-cycle operation decoder for the parametrised LIFO stack.
// STACK_SWAP_EN adds the swap input to the decoder.
package param_stack_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_SWAP
  } stack_op_e;

  typedef struct packed {
    stack_op_e op;
    logic      set_overflow;
    logic      set_underflow;
  } stack_dec_t;

  // Priority: push&pop, push, pop, swap. Swap combined with push or pop is dropped silently.
  function automatic stack_dec_t decode_op(
    input logic        push,
    input logic        pop,
`ifdef STACK_SWAP_EN
    input logic        swap,
`endif
    input int unsigned count,
    input int unsigned depth
  );
    stack_dec_t dec;
    dec.op            = OP_NONE;
    dec.set_overflow  = 1'b0;
    dec.set_underflow = 1'b0;
    if (push && pop) begin
      if (count > 0) begin
        dec.op = OP_REPLACE;
      end else begin
        dec.op            = OP_PUSH;
        dec.set_underflow = 1'b1;
      end
    end else if (push) begin
      if (count < depth) dec.op = OP_PUSH;
      else               dec.set_overflow = 1'b1;
    end else if (pop) begin
      if (count > 0) dec.op = OP_POP;
      else           dec.set_underflow = 1'b1;
    end
`ifdef STACK_SWAP_EN
    else if (swap) begin
      if (count >= 2) dec.op = OP_SWAP;
      else            dec.set_underflow = 1'b1;
    end
`endif
    return dec;
  endfunction

endpackage

// File: rtl/param_stack_regfile.sv
// Stack storage: flop array with one write port, two combinational read ports
// and a swap mode that exchanges the entries at idx_a and idx_b.
module stack_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             swap_en,
  input  logic [IDX_W-1:0] idx_a,
  input  logic [IDX_W-1:0] idx_b,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; the top level masks reads by occupancy.
  always_ff @(posedge clock) begin
    if (swap_en) begin
      mem[idx_a] <= mem[idx_b];
      mem[idx_b] <= mem[idx_a];
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Indices past the last entry occur for non-power-of-two depths when nearly empty.
  assign rd_a = (32'(idx_a) < DEPTH) ? mem[idx_a] : '0;
  assign rd_b = (32'(idx_b) < DEPTH) ? mem[idx_b] : '0;

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO operand stack with occupancy count, sticky error flags and replace-top.
// STACK_SWAP_EN adds the swap port and the exchange-top-two operation.
module param_stack
  import param_stack_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
`ifdef STACK_SWAP_EN
  input  logic             swap,
`endif
  input  logic             clear_err,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out_1st,
  output logic [WIDTH-1:0] data_out_2nd,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int IDX_W = $clog2(DEPTH);

  stack_dec_t       dec;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] below_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;
  logic             swap_en;
  logic [WIDTH-1:0] rd_top;
  logic [WIDTH-1:0] rd_below;

  always_comb begin
    dec = decode_op(push, pop,
`ifdef STACK_SWAP_EN
                    swap,
`endif
                    32'(count), DEPTH);
  end

  assign top_idx   = IDX_W'(count - CNT_W'(1));
  assign below_idx = IDX_W'(count - CNT_W'(2));
  assign wr_en     = (dec.op == OP_PUSH) || (dec.op == OP_REPLACE);
  assign wr_idx    = (dec.op == OP_REPLACE) ? top_idx : IDX_W'(count);
  assign swap_en   = (dec.op == OP_SWAP);

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (data_in),
    .swap_en (swap_en),
    .idx_a   (top_idx),
    .idx_b   (below_idx),
    .rd_a    (rd_top),
    .rd_b    (rd_below)
  );

  // A flag being set wins over clear_err in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (dec.op)
        OP_PUSH: count <= count + CNT_W'(1);
        OP_POP:  count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      overflow  <= dec.set_overflow  | (overflow  & ~clear_err);
      underflow <= dec.set_underflow | (underflow & ~clear_err);
    end
  end

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign data_out_1st = (count >= CNT_W'(1)) ? rd_top   : '0;
  assign data_out_2nd = (count >= CNT_W'(2)) ? rd_below : '0;

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack: a queue-based stack model predicts each cycle's outputs.
// Build with STACK_SWAP_EN to exercise the swap path as well.
module tb_param_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 6;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset_n;
  logic             push, pop, swap, clear_err;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out_1st, data_out_2nd;
  logic [CNT_W-1:0] count;
  logic             empty, full, overflow, underflow;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .push         (push),
    .pop          (pop),
`ifdef STACK_SWAP_EN
    .swap         (swap),
`endif
    .clear_err    (clear_err),
    .data_in      (data_in),
    .data_out_1st (data_out_1st),
    .data_out_2nd (data_out_2nd),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cnt;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic emp;
    logic ful;
    logic ovf;
    logic unf;
  } exp_t;

  exp_t exp_q[$];
  logic [WIDTH-1:0] stk[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  bit release_pending = 1'b0;
  event chk_ev;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    int unsigned n = stk.size();
    e.cnt = n;
    e.d1  = (n >= 1) ? stk[n-1] : '0;
    e.d2  = (n >= 2) ? stk[n-2] : '0;
    e.emp = (n == 0);
    e.ful = (n == DEPTH);
    e.ovf = m_ovf;
    e.unf = m_unf;
    return e;
  endfunction

  task automatic model_reset();
    stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic q, input logic s, input logic c,
                            input logic [WIDTH-1:0] d);
    logic so, su;
    logic [WIDTH-1:0] t;
    so = 1'b0;
    su = 1'b0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (p && q) begin
      if (stk.size() > 0) stk[stk.size()-1] = d;
      else begin stk.push_back(d); su = 1'b1; end
    end else if (p) begin
      if (stk.size() < DEPTH) stk.push_back(d);
      else so = 1'b1;
    end else if (q) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else su = 1'b1;
    end else if (s) begin
`ifdef STACK_SWAP_EN
      if (stk.size() >= 2) begin
        t = stk[stk.size()-1];
        stk[stk.size()-1] = stk[stk.size()-2];
        stk[stk.size()-2] = t;
      end else su = 1'b1;
`endif
    end
    m_ovf = so | (m_ovf & ~c);
    m_unf = su | (m_unf & ~c);
  endtask

  task automatic op(input logic p, input logic q, input logic s, input logic c,
                    input logic [WIDTH-1:0] d);
    @(negedge clock);
    if (release_pending) begin
      reset_n = 1'b1;
      release_pending = 1'b0;
    end
    push = p; pop = q; swap = s; clear_err = c; data_in = d;
    model_step(p, q, s, c, d);
    exp_q.push_back(snapshot());
  endtask

  // Monitor: compares after every rising edge, and on demand for async reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count",        32'(count),        32'(e.cnt));
        check("empty",        32'(empty),        32'(e.emp));
        check("full",         32'(full),         32'(e.ful));
        check("data_out_1st", 32'(data_out_1st), 32'(e.d1));
        check("data_out_2nd", 32'(data_out_2nd), 32'(e.d2));
        check("overflow",     32'(overflow),     32'(e.ovf));
        check("underflow",    32'(underflow),    32'(e.unf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int guard;
    reset_n = 1'b0;
    push = 0; pop = 0; swap = 0; clear_err = 0; data_in = '0;
    #2;
    model_reset();
    exp_q.push_back(snapshot());
    ->chk_ev;
    release_pending = 1'b1;

    op(1, 0, 0, 0, 16'h000A);
    op(1, 0, 0, 0, 16'h000B);
    op(1, 0, 0, 0, 16'h000C);
    op(0, 1, 0, 0, '0);
    op(0, 1, 0, 0, '0);
    op(0, 1, 0, 0, '0);

    for (int i = 0; i < DEPTH; i++) op(1, 0, 0, 0, 16'(16'h100 + i));
    op(1, 0, 0, 0, 16'hDEAD);
    op(1, 1, 0, 0, 16'hBEEF);
    op(0, 0, 0, 1, '0);

    for (int i = 0; i < DEPTH; i++) op(0, 1, 0, 0, '0);
    op(0, 1, 0, 0, '0);
    op(0, 1, 0, 1, '0);
    op(0, 0, 0, 1, '0);
    op(1, 1, 0, 0, 16'h0055);
    op(0, 0, 0, 1, '0);
    op(0, 1, 0, 0, '0);

    op(1, 0, 0, 0, 16'h0001);
    op(1, 0, 0, 0, 16'h0002);
    op(0, 0, 1, 0, '0);
    op(1, 0, 1, 0, 16'h0003);
    op(0, 1, 1, 0, '0);
    op(0, 1, 0, 0, '0);
    op(0, 0, 1, 0, '0);
    op(0, 0, 0, 1, '0);
    op(0, 1, 0, 0, '0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      op(r < 6, (r >= 5 && r < 10), (r >= 10 && r < 13), ($urandom_range(0, 7) == 0),
         16'($urandom));
    end

    while (stk.size() < 5) op(1, 0, 0, 0, 16'($urandom));
    while (stk.size() > 5) op(0, 1, 0, 0, '0);
    op(0, 0, 0, 0, '0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    model_reset();
    exp_q.push_back(snapshot());
    ->chk_ev;
    op(1, 0, 0, 0, 16'h1234);
    release_pending = 1'b1;
    op(1, 0, 0, 0, 16'h0007);
    op(0, 0, 0, 0, '0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clock);
      guard++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
